// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the single-port RAM and ram_arbiter.
// The arbiter uses the slave modport; the requesters and RAM together form the master side.
interface ram_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_rnw;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic          ram_cs_b;
  logic          ram_rnw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    input  dma_req, dma_rnw, dma_addr, dma_wdata,
    input  ram_dout,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output ram_cs_b, ram_rnw, ram_addr, ram_din, busy
  );

  modport master (
    output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    output dma_req, dma_rnw, dma_addr, dma_wdata,
    output ram_dout,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  ram_cs_b, ram_rnw, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between CPU and DMA: one access per request, 3 cycles each.
// Round-robin by default; define CPU_PRIORITY_EN to make the CPU win every tie.
module ram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic G_CPU = 1'b0;
  localparam logic G_DMA = 1'b1;

  logic [1:0]    state_q,      state_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_q,      grant_d;
  logic          ram_cs_b_q,   ram_cs_b_d;
  logic          ram_rnw_q,    ram_rnw_d;
  logic [AW-1:0] ram_addr_q,   ram_addr_d;
  logic [DW-1:0] ram_din_q,    ram_din_d;
  logic          cpu_ack_q,    cpu_ack_d;
  logic          dma_ack_q,    dma_ack_d;
  logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q,  dma_rdata_d;
  logic          busy_q,       busy_d;

  logic          any_req;
  logic          winner;

  assign any_req = bus.cpu_req | bus.dma_req;

  always_comb begin
    winner = G_CPU;
`ifdef CPU_PRIORITY_EN
    winner = bus.cpu_req ? G_CPU : G_DMA;
`else
    // On a tie the requester that did not win last time goes next.
    if (bus.cpu_req && bus.dma_req) begin
      winner = (last_grant_q == G_CPU) ? G_DMA : G_CPU;
    end else begin
      winner = bus.cpu_req ? G_CPU : G_DMA;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ram_cs_b_d   = ram_cs_b_q;
    ram_rnw_d    = ram_rnw_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    case (state_q)
      S_IDLE: begin
        ram_cs_b_d = 1'b1;
        if (any_req) begin
          // The payload is latched here and nowhere else, so later changes are harmless.
          grant_d      = winner;
          last_grant_d = winner;
          ram_cs_b_d   = 1'b0;
          if (winner == G_CPU) begin
            ram_rnw_d  = bus.cpu_rnw;
            ram_addr_d = bus.cpu_addr;
            ram_din_d  = bus.cpu_wdata;
          end else begin
            ram_rnw_d  = bus.dma_rnw;
            ram_addr_d = bus.dma_addr;
            ram_din_d  = bus.dma_wdata;
          end
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // The RAM did its work on the negedge inside this cycle; ram_dout is settled now.
        ram_cs_b_d = 1'b1;
        if (grant_q == G_CPU) begin
          cpu_ack_d = 1'b1;
          if (ram_rnw_q) begin
            cpu_rdata_d = bus.ram_dout;
          end
        end else begin
          dma_ack_d = 1'b1;
          if (ram_rnw_q) begin
            dma_rdata_d = bus.ram_dout;
          end
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        ram_cs_b_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        ram_cs_b_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= G_DMA;
      grant_q      <= G_CPU;
      ram_cs_b_q   <= 1'b1;
      ram_rnw_q    <= 1'b1;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ram_cs_b_q   <= ram_cs_b_d;
      ram_rnw_q    <= ram_rnw_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ram_cs_b  = ram_cs_b_q;
  assign bus.ram_rnw   = ram_rnw_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.busy      = busy_q;

endmodule
